// File: rtl/seq_counter_ctrl_if.sv
// Host/config and status bundle for seq_counter_ctrl.
// master: cfg_*, start, steps, stop out; state, busy, done, wrap in.
interface seq_counter_ctrl_if #(
   parameter int SW = 3,
   parameter int CW = 8
);
   logic          cfg_we;
   logic [SW-1:0] cfg_addr;
   logic [SW-1:0] cfg_data;
   logic          start;
   logic [CW-1:0] steps;
   logic          stop;
   logic [SW-1:0] state;
   logic          busy;
   logic          done;
   logic          wrap;

   modport master (
      output cfg_we, cfg_addr, cfg_data,
      output start, steps, stop,
      input  state, busy, done, wrap
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_data,
      input  start, steps, stop,
      output state, busy, done, wrap
   );
endinterface

// File: rtl/seq_counter_ctrl.sv
// Run controller for a table-driven custom-sequence state counter.
// Ports: clk, rst (async high), bus (seq_counter_ctrl_if.slave).
module seq_counter_ctrl #(
   parameter int SW = 3,
   parameter int CW = 8
) (
   input logic              clk,
   input logic              rst,
   seq_counter_ctrl_if.slave bus
);
   localparam int N = 2**SW;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fsm_t;

   fsm_t          fsm_q, fsm_d;
   logic [SW-1:0] state_q;
   logic [CW-1:0] rem_q;
   logic          free_q;
   logic          wrap_q;
   logic [SW-1:0] tbl [N];
   logic          adv;
   logic          load;
   logic [SW-1:0] nxt;

   // Reset sequence: evens ascending, then odds, then back to 0.
   // The top odd entry is unreachable and recovers to 0.
   function automatic logic [SW-1:0] dflt(input int i);
      int nx;
      nx = i + 2;
      if (i % 2 == 0)
         return (nx < N) ? SW'(nx) : SW'(1);
      else
         return (nx < N - 1) ? SW'(nx) : '0;
   endfunction

   assign nxt = tbl[state_q];

   always_comb begin
      fsm_d = fsm_q;
      adv   = 1'b0;
      load  = 1'b0;
      case (fsm_q)
         IDLE: begin
            if (bus.start) begin
               fsm_d = RUN;
               load  = 1'b1;
            end
         end
         DONE: begin
            if (bus.start) begin
               fsm_d = RUN;
               load  = 1'b1;
            end else begin
               fsm_d = IDLE;
            end
         end
         RUN: begin
            if (bus.stop) begin
               fsm_d = IDLE;
            end else begin
               adv = 1'b1;
               if (!free_q && rem_q == CW'(1))
                  fsm_d = DONE;
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q   <= IDLE;
         state_q <= '0;
         rem_q   <= '0;
         free_q  <= 1'b0;
         wrap_q  <= 1'b0;
         for (int i = 0; i < N; i++)
            tbl[i] <= dflt(i);
      end else begin
         fsm_q  <= fsm_d;
         wrap_q <= adv && (nxt == '0)
                   && (state_q != '0);
         if (adv)
            state_q <= nxt;
         if (load) begin
            rem_q  <= bus.steps;
            free_q <= (bus.steps == '0);
         end else if (adv && !free_q) begin
            rem_q <= rem_q - CW'(1);
         end
         // Writes land in IDLE/DONE only, so the
         // table never changes under a live run.
         if (bus.cfg_we && fsm_q != RUN)
            tbl[bus.cfg_addr] <= bus.cfg_data;
      end
   end

   assign bus.state = state_q;
   assign bus.busy  = (fsm_q == RUN);
   assign bus.done  = (fsm_q == DONE);
   assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_seq_counter_ctrl.sv
// Self-checking bench for seq_counter_ctrl.
// Model: table array iterated per advance, runs as step lists.
module tb_seq_counter_ctrl;
   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [2:0] mtbl [8];
   logic [2:0] mstate;

   seq_counter_ctrl_if #(.SW(3), .CW(8)) bus ();

   seq_counter_ctrl #(.SW(3), .CW(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d",
                tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset;
      logic [2:0] d [8];
      d = '{3'd2, 3'd3, 3'd4, 3'd5,
            3'd6, 3'd0, 3'd1, 3'd0};
      for (int i = 0; i < 8; i++)
         mtbl[i] = d[i];
      mstate = 3'd0;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      model_reset();
      chk("rst_state", 32'(bus.state), 0);
      chk("rst_busy", 32'(bus.busy), 0);
   endtask

   task automatic wr(input logic [2:0] a,
                     input logic [2:0] d);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = a;
      bus.cfg_data = d;
      tick;
      bus.cfg_we = 1'b0;
      mtbl[a] = d;
   endtask

   // One edge inside a run, advancing the model.
   task automatic step(input bit eb, input bit ed);
      logic [2:0] nx;
      tick;
      nx = mtbl[mstate];
      chk("state", 32'(bus.state), 32'(nx));
      chk("wrap", 32'(bus.wrap),
          32'(nx == 0 && mstate != 0));
      chk("busy", 32'(bus.busy), 32'(eb));
      chk("done", 32'(bus.done), 32'(ed));
      mstate = nx;
   endtask

   task automatic run(input int n,
                      input int wat,
                      input logic [2:0] wa,
                      input logic [2:0] wd,
                      input int rlo,
                      input int rhi,
                      input bit ws,
                      input logic [2:0] wsa,
                      input logic [2:0] wsd);
      bus.start    = 1'b1;
      bus.steps    = 8'(n);
      bus.cfg_we   = ws;
      bus.cfg_addr = wsa;
      bus.cfg_data = wsd;
      if (ws) mtbl[wsa] = wsd;
      tick;
      bus.start  = 1'b0;
      bus.cfg_we = 1'b0;
      bus.steps  = 8'($urandom);
      chk("go_busy", 32'(bus.busy), 1);
      chk("go_hold", 32'(bus.state), 32'(mstate));
      chk("go_done", 32'(bus.done), 0);
      for (int i = 1; i <= n; i++) begin
         bus.start    = (i >= rlo && i <= rhi);
         bus.cfg_we   = (i == wat);
         bus.cfg_addr = wa;
         bus.cfg_data = wd;
         step(i < n, i == n);
      end
      bus.start  = 1'b0;
      bus.cfg_we = 1'b0;
      tick;
      chk("end_done", 32'(bus.done), 0);
      chk("end_busy", 32'(bus.busy), 0);
      chk("end_wrap", 32'(bus.wrap), 0);
      chk("end_hold", 32'(bus.state), 32'(mstate));
   endtask

   initial begin
      int k;
      int n;
      int wat;
      int rlo;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.cfg_we = 1'b0;
      bus.cfg_addr = '0;
      bus.cfg_data = '0;
      bus.start = 1'b0;
      bus.steps = '0;
      bus.stop = 1'b0;
      model_reset();
      #2;
      chk("r_state", 32'(bus.state), 0);
      chk("r_busy", 32'(bus.busy), 0);
      chk("r_done", 32'(bus.done), 0);
      chk("r_wrap", 32'(bus.wrap), 0);
      tick;
      tick;
      rst = 1'b0;

      // 1: bounded run through the default sequence
      run(7, -1, 0, 0, 0, -1, 0, 0, 0);
      chk("s1_final", 32'(bus.state), 0);

      // 2: free run, stop at state 6
      bus.start = 1'b1;
      bus.steps = 8'd0;
      tick;
      bus.start = 1'b0;
      chk("fr_busy", 32'(bus.busy), 1);
      for (int c = 0; c < 20; c++)
         step(1, 0);
      k = 0;
      while (mstate != 6 && k < 8) begin
         step(1, 0);
         k++;
      end
      chk("fr_at6", 32'(bus.state), 6);
      bus.stop = 1'b1;
      tick;
      bus.stop = 1'b0;
      chk("stop_st", 32'(bus.state), 6);
      chk("stop_busy", 32'(bus.busy), 0);
      chk("stop_done", 32'(bus.done), 0);
      chk("stop_wrap", 32'(bus.wrap), 0);
      tick;
      chk("stop_done2", 32'(bus.done), 0);
      chk("stop_hold", 32'(bus.state), 6);

      // 3: increment table, dropped write while busy
      do_reset();
      for (int i = 0; i < 8; i++)
         wr(3'(i), 3'(i + 1));
      run(8, -1, 0, 0, 0, -1, 0, 0, 0);
      chk("s3_final", 32'(bus.state), 0);
      run(8, 3, 3'd0, 3'd5, 0, -1, 0, 0, 0);
      chk("s3_rpt", 32'(bus.state), 0);

      // 4: restart pulses ignored mid-run
      run(5, -1, 0, 0, 2, 3, 0, 0, 0);

      // 5: async reset mid-run at state 4
      bus.start = 1'b1;
      bus.steps = 8'd20;
      tick;
      bus.start = 1'b0;
      k = 0;
      while (mstate != 4 && k < 8) begin
         step(1, 0);
         k++;
      end
      chk("pre_rst4", 32'(bus.state), 4);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_state", 32'(bus.state), 0);
      chk("ar_busy", 32'(bus.busy), 0);
      chk("ar_done", 32'(bus.done), 0);
      chk("ar_wrap", 32'(bus.wrap), 0);
      tick;
      rst = 1'b0;
      model_reset();
      run(3, -1, 0, 0, 0, -1, 0, 0, 0);
      chk("s5_final", 32'(bus.state), 6);

      // 6: illegal state 7 recovers to 0
      do_reset();
      wr(3'd0, 3'd7);
      run(2, -1, 0, 0, 0, -1, 0, 0, 0);
      chk("s6_final", 32'(bus.state), 0);

      // write on the start edge takes effect at once
      run(1, -1, 0, 0, 0, -1, 1, 3'd0, 3'd3);
      chk("wstart", 32'(bus.state), 3);

      // randomized tables and runs
      for (int r = 0; r < 20; r++) begin
         for (int w = 0; w < 2; w++)
            wr(3'($urandom), 3'($urandom));
         n = int'($urandom_range(1, 10));
         wat = ($urandom_range(0, 1) == 1)
               ? int'($urandom_range(1, n)) : -1;
         rlo = int'($urandom_range(1, n));
         run(n, wat, 3'($urandom), 3'($urandom),
             rlo, rlo + int'($urandom_range(0, 2)) > n
                  ? n : rlo + 1,
             1'($urandom), 3'($urandom),
             3'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
